// File: rtl/spi_target_regs_if.sv
// spi_target_regs_if
// Signal bundle for the SPI register target.
//   slave  modport : the target (spi_target_regs) side.
//   master modport : the SPI host / monitor side.
// Signals:
//   spi_sck_i, spi_csb_i, spi_sd_i : SPI clock, active-low select, MOSI
//   spi_sd_o, spi_sd_en_o          : MISO data and its output enable
//   regs_o                         : flat register bank, reg n = [8n+7:8n]
//   wr_valid_o/wr_addr_o/wr_data_o : one-cycle notification per written byte
//   busy_o                         : transaction in progress
//   state_o                        : FSM state (IDLE=0, CMD=1, WDATA=2, RDATA=3)
interface spi_target_regs_if #(
    parameter int NumRegs = 16
);
    localparam int AddrW = $clog2(NumRegs);

    logic                   spi_sck_i;
    logic                   spi_csb_i;
    logic                   spi_sd_i;
    logic                   spi_sd_o;
    logic                   spi_sd_en_o;
    logic [NumRegs*8-1:0]   regs_o;
    logic                   wr_valid_o;
    logic [AddrW-1:0]       wr_addr_o;
    logic [7:0]             wr_data_o;
    logic                   busy_o;
    logic [1:0]             state_o;

    modport slave (
        input  spi_sck_i, spi_csb_i, spi_sd_i,
        output spi_sd_o, spi_sd_en_o, regs_o,
        output wr_valid_o, wr_addr_o, wr_data_o, busy_o, state_o
    );

    modport master (
        output spi_sck_i, spi_csb_i, spi_sd_i,
        input  spi_sd_o, spi_sd_en_o, regs_o,
        input  wr_valid_o, wr_addr_o, wr_data_o, busy_o, state_o
    );
endinterface

// File: rtl/spi_target_regs.sv
// spi_target_regs
// SPI mode-0 target with a byte-addressed register bank. All SPI inputs are
// oversampled in the clk_i domain. A transaction is a command byte
// (bit7 = read, low bits = start address) followed by auto-incrementing
// data bytes, MSB first.
// Ports:
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset
//   bus    : spi_target_regs_if.slave (SPI pins, register bank, write
//            notification, busy and FSM state)
// Write notification: wr_valid_o is a one-cycle pulse; wr_addr_o/wr_data_o
// carry that write and hold until the next one. There is no back-pressure.
module spi_target_regs #(
    parameter int                   NumRegs    = 16,
    parameter logic [NumRegs*8-1:0] ResetVal   = '0,
    parameter int                   SyncStages = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    spi_target_regs_if.slave   bus
);
    localparam int AddrW = $clog2(NumRegs);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [SyncStages-1:0]     sck_sync_q, sck_sync_d;
    logic [SyncStages-1:0]     csb_sync_q, csb_sync_d;
    logic [SyncStages-1:0]     sd_sync_q, sd_sync_d;
    logic [SyncStages-1:0]     vld_q, vld_d;
    logic                      sck_prev_q, sck_prev_d;
    logic                      csb_prev_q, csb_prev_d;
    logic                      armed_q, armed_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [6:0]                rx_shift_q, rx_shift_d;
    logic [AddrW-1:0]          addr_q, addr_d;
    logic [7:0]                tx_shift_q, tx_shift_d;
    logic                      sd_en_q, sd_en_d;
    logic                      load_pending_q, load_pending_d;
    logic [NumRegs-1:0][7:0]   regs_q, regs_d;
    logic                      wr_valid_q, wr_valid_d;
    logic [AddrW-1:0]          wr_addr_q, wr_addr_d;
    logic [7:0]                wr_data_q, wr_data_d;

    logic       sck_s, csb_s, sd_s;
    logic       sck_rise, sck_fall, csb_fall, csb_rise;
    logic       bit_active, byte_done;
    logic [7:0] rx_byte;

    // Synchronizer chains. vld tracks when the chain output holds a real pin
    // sample instead of its reset value.
    always_comb begin
        sck_sync_d = {sck_sync_q[SyncStages-2:0], bus.spi_sck_i};
        csb_sync_d = {csb_sync_q[SyncStages-2:0], bus.spi_csb_i};
        sd_sync_d  = {sd_sync_q[SyncStages-2:0], bus.spi_sd_i};
        vld_d      = {vld_q[SyncStages-2:0], 1'b1};
    end

    assign sck_s = sck_sync_q[SyncStages-1];
    assign csb_s = csb_sync_q[SyncStages-1];
    assign sd_s  = sd_sync_q[SyncStages-1];

    assign sck_prev_d = sck_s;
    assign csb_prev_d = csb_s;

    // csb must be seen high at least once after reset before a falling edge
    // may start a transaction; otherwise a select held low across reset would
    // look like a fresh csb fall once the synchronizer flushes.
    assign armed_d = armed_q | (vld_q[SyncStages-1] & csb_s);

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign csb_fall = ~csb_s & csb_prev_q & armed_q;
    assign csb_rise = csb_s & ~csb_prev_q;

    assign bit_active = (state_q != IDLE) && sck_rise;
    assign byte_done  = bit_active && (bit_cnt_q == 3'd7);
    assign rx_byte    = {rx_shift_q, sd_s};

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        addr_d         = addr_q;
        tx_shift_d     = tx_shift_q;
        sd_en_d        = sd_en_q;
        load_pending_d = load_pending_q;
        regs_d         = regs_q;
        wr_valid_d     = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;

        if (bit_active) begin
            rx_shift_d = rx_byte[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
        end

        case (state_q)
            IDLE: begin
                if (csb_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = 3'd0;
                end
            end
            CMD: begin
                if (byte_done) begin
                    addr_d         = rx_byte[AddrW-1:0];
                    state_d        = rx_byte[7] ? RDATA : WDATA;
                    load_pending_d = rx_byte[7];
                end
            end
            WDATA: begin
                if (byte_done) begin
                    regs_d[addr_q] = rx_byte;
                    wr_valid_d     = 1'b1;
                    wr_addr_d      = addr_q;
                    wr_data_d      = rx_byte;
                    addr_d         = addr_q + AddrW'(1);
                end
            end
            RDATA: begin
                // The address advances at byte completion; the following sck
                // fall loads the register at the (new) address.
                if (byte_done) begin
                    addr_d         = addr_q + AddrW'(1);
                    load_pending_d = 1'b1;
                end
                if (sck_fall) begin
                    if (load_pending_q) begin
                        tx_shift_d     = regs_q[addr_q];
                        sd_en_d        = 1'b1;
                        load_pending_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Deselect wins over everything except a byte completing in the same
        // cycle, whose write has already been committed above.
        if ((state_q != IDLE) && csb_rise) begin
            state_d        = IDLE;
            bit_cnt_d      = 3'd0;
            tx_shift_d     = 8'd0;
            sd_en_d        = 1'b0;
            load_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            sck_sync_q     <= '0;
            csb_sync_q     <= '1;
            sd_sync_q      <= '0;
            vld_q          <= '0;
            sck_prev_q     <= 1'b0;
            csb_prev_q     <= 1'b1;
            armed_q        <= 1'b0;
            bit_cnt_q      <= 3'd0;
            rx_shift_q     <= 7'd0;
            addr_q         <= '0;
            tx_shift_q     <= 8'd0;
            sd_en_q        <= 1'b0;
            load_pending_q <= 1'b0;
            regs_q         <= ResetVal;
            wr_valid_q     <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= 8'd0;
        end else begin
            state_q        <= state_d;
            sck_sync_q     <= sck_sync_d;
            csb_sync_q     <= csb_sync_d;
            sd_sync_q      <= sd_sync_d;
            vld_q          <= vld_d;
            sck_prev_q     <= sck_prev_d;
            csb_prev_q     <= csb_prev_d;
            armed_q        <= armed_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            addr_q         <= addr_d;
            tx_shift_q     <= tx_shift_d;
            sd_en_q        <= sd_en_d;
            load_pending_q <= load_pending_d;
            regs_q         <= regs_d;
            wr_valid_q     <= wr_valid_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
        end
    end

    assign bus.spi_sd_o    = tx_shift_q[7];
    assign bus.spi_sd_en_o = sd_en_q;
    assign bus.regs_o      = regs_q;
    assign bus.wr_valid_o  = wr_valid_q;
    assign bus.wr_addr_o   = wr_addr_q;
    assign bus.wr_data_o   = wr_data_q;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.state_o     = state_q;
endmodule

// File: tb/tb_spi_target_regs.sv
// tb_spi_target_regs
// Bench for spi_target_regs: SPI mode-0 host driver tasks, a register model,
// write/read expectation queues, and one task per scenario.
module tb_spi_target_regs;
    localparam int NUM_REGS = 16;
    localparam int SYNC     = 2;
    localparam int H        = SYNC + 2;   // sck half period in clk cycles
    localparam logic [127:0] RESET_VAL = 128'h1F1E1D1C1B1A19181716151413121110;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_target_regs_if #(.NumRegs(NUM_REGS)) bus ();

    spi_target_regs #(
        .NumRegs    (NUM_REGS),
        .ResetVal   (RESET_VAL),
        .SyncStages (SYNC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] wr_exp_q[$];     // {addr, data}
    logic [7:0]  rd_exp_q[$];
    logic [7:0]  model[NUM_REGS];
    logic [7:0]  burst_buf[8];

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        logic [127:0] rv;
        rv = RESET_VAL;
        for (int i = 0; i < NUM_REGS; i++) model[i] = rv[8*i +: 8];
    endtask

    function automatic logic [127:0] model_vec();
        logic [127:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[8*i +: 8] = model[i];
        return v;
    endfunction

    // Write-notification monitor: every pulse must match the oldest expected write.
    initial begin
        logic [11:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (bus.wr_valid_o === 1'b1) begin
                n_checks++;
                if (wr_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_pulse: unexpected write addr=%0d data=%h, none expected",
                             bus.wr_addr_o, bus.wr_data_o);
                end else begin
                    exp = wr_exp_q.pop_front();
                    if ({bus.wr_addr_o, bus.wr_data_o} !== exp) begin
                        n_fail++;
                        $display("FAIL wr_pulse: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 bus.wr_addr_o, bus.wr_data_o, exp[11:8], exp[7:0]);
                    end
                end
            end
        end
    end

    // ---------------- SPI host driver ----------------
    task automatic spi_begin();
        bus.spi_csb_i = 1'b0;
        wait_clks(H);
    endtask

    task automatic spi_end();
        wait_clks(H);
        bus.spi_csb_i = 1'b1;
        wait_clks(H + 4);
    endtask

    // Clocks nbits of tx (MSB first). MISO and its enable are sampled just
    // before each rising edge, as a mode-0 host does.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit csb_on_last,
                            output logic [7:0] rx, output bit en_any, output bit en_all);
        rx     = 8'd0;
        en_any = 1'b0;
        en_all = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_sd_i = tx[7-i];
            wait_clks(H);
            rx     = {rx[6:0], bus.spi_sd_o};
            en_any = en_any | (bus.spi_sd_en_o === 1'b1);
            en_all = en_all & (bus.spi_sd_en_o === 1'b1);
            bus.spi_sck_i = 1'b1;
            if (csb_on_last && (i == nbits - 1)) bus.spi_csb_i = 1'b1;
            wait_clks(H);
            bus.spi_sck_i = 1'b0;
        end
    endtask

    task automatic do_write(input logic [7:0] cmd, input int len);
        logic [7:0] rx;
        bit         ea, el;
        logic [3:0] a;
        spi_begin();
        spi_bits(cmd, 8, 1'b0, rx, ea, el);
        a = cmd[3:0];
        for (int k = 0; k < len; k++) begin
            wr_exp_q.push_back({a, burst_buf[k]});
            model[a] = burst_buf[k];
            spi_bits(burst_buf[k], 8, 1'b0, rx, ea, el);
            a = a + 4'd1;
        end
        spi_end();
    endtask

    task automatic do_read(input logic [7:0] cmd, input int len);
        logic [7:0] rx, exp;
        bit         ea, el;
        logic [3:0] a;
        spi_begin();
        spi_bits(cmd, 8, 1'b0, rx, ea, el);
        n_checks++;
        if (ea !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_en_cmd: sd_en seen=%0b during command byte, expected 0", ea);
        end
        a = cmd[3:0];
        for (int k = 0; k < len; k++) begin
            rd_exp_q.push_back(model[a]);
            spi_bits(8'($urandom_range(0, 255)), 8, 1'b0, rx, ea, el);
            exp = rd_exp_q.pop_front();
            n_checks++;
            if (rx !== exp) begin
                n_fail++;
                $display("FAIL rd_data: addr=%0d got %h, expected %h", a, rx, exp);
            end
            n_checks++;
            if (el !== 1'b1) begin
                n_fail++;
                $display("FAIL rd_en_data: sd_en all-high=%0b, expected 1", el);
            end
            a = a + 4'd1;
        end
        spi_end();
        n_checks++;
        if ({bus.spi_sd_en_o, bus.spi_sd_o, bus.busy_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL rd_release: en/sd/busy=%b, expected 000",
                     {bus.spi_sd_en_o, bus.spi_sd_o, bus.busy_o});
        end
    endtask

    task automatic check_bank(input string name);
        n_checks++;
        if (bus.regs_o !== model_vec()) begin
            n_fail++;
            $display("FAIL %s: regs_o=%h, expected %h", name, bus.regs_o, model_vec());
        end
        n_checks++;
        if (wr_exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_wr_pending: %0d writes not seen, expected 0", name, wr_exp_q.size());
            wr_exp_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        wait_clks(3);
        n_checks++;
        if ({bus.spi_sd_o, bus.spi_sd_en_o, bus.wr_valid_o, bus.busy_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outs: sd/en/wv/busy=%b, expected 0000",
                     {bus.spi_sd_o, bus.spi_sd_en_o, bus.wr_valid_o, bus.busy_o});
        end
        n_checks++;
        if ({bus.wr_addr_o, bus.wr_data_o} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_wr: addr/data=%h, expected 000", {bus.wr_addr_o, bus.wr_data_o});
        end
        rst = 1'b0;
        wait_clks(4);
        n_checks++;
        if (bus.regs_o !== RESET_VAL) begin
            n_fail++;
            $display("FAIL reset_regs: regs_o=%h, expected %h", bus.regs_o, RESET_VAL);
        end
        n_checks++;
        if (bus.state_o !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d, expected 0", bus.state_o);
        end
    endtask

    task automatic test_write_burst();
        logic [7:0] rx;
        bit         ea, el;
        spi_begin();
        wait_clks(40);   // csb low, no sck: state must hold
        n_checks++;
        if (bus.state_o !== 2'd1 || bus.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_hold: state=%0d busy=%0b, expected 1/1", bus.state_o, bus.busy_o);
        end
        spi_bits(8'h02, 8, 1'b0, rx, ea, el);
        wr_exp_q.push_back({4'd2, 8'hA5}); model[2] = 8'hA5;
        spi_bits(8'hA5, 8, 1'b0, rx, ea, el);
        wr_exp_q.push_back({4'd3, 8'h3C}); model[3] = 8'h3C;
        spi_bits(8'h3C, 8, 1'b0, rx, ea, el);
        spi_end();
        check_bank("wr_burst");
        n_checks++;
        if ({bus.wr_addr_o, bus.wr_data_o} !== {4'd3, 8'h3C} || bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_hold_out: addr/data=%h busy=%0b, expected 33c/0",
                     {bus.wr_addr_o, bus.wr_data_o}, bus.busy_o);
        end
    endtask

    task automatic test_read_burst();
        do_read(8'h82, 2);
    endtask

    task automatic test_wrap();
        burst_buf[0] = 8'h11;
        burst_buf[1] = 8'h22;
        do_write(8'h0F, 2);
        check_bank("wrap_wr");
        do_read(8'h8F, 2);
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        bit         ea, el;
        spi_begin();
        spi_bits(8'h05, 8, 1'b0, rx, ea, el);
        spi_bits(8'hFF, 5, 1'b0, rx, ea, el);
        spi_end();
        check_bank("abort");
        burst_buf[0] = 8'h5A;
        do_write(8'h07, 1);
        check_bank("abort_next");
        do_read(8'h85, 1);
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        bit         ea, el;
        spi_begin();
        spi_bits(8'h04, 8, 1'b0, rx, ea, el);
        spi_bits(8'hC3, 4, 1'b0, rx, ea, el);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        model_reset();
        wait_clks(2);
        n_checks++;
        if (bus.regs_o !== RESET_VAL || bus.busy_o !== 1'b0 || bus.spi_sd_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: regs=%h busy=%0b en=%0b, expected reset image/0/0",
                     bus.regs_o, bus.busy_o, bus.spi_sd_en_o);
        end
        // csb is still low: the remaining edges must not start anything.
        spi_bits(8'h30, 4, 1'b0, rx, ea, el);
        spi_bits(8'h99, 8, 1'b0, rx, ea, el);
        n_checks++;
        if (bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_idle: busy=%0b, expected 0", bus.busy_o);
        end
        spi_end();
        check_bank("rst_mid");
        burst_buf[0] = 8'h77;
        do_write(8'h09, 1);
        check_bank("rst_mid_next");
    endtask

    task automatic test_csb_with_last_rise();
        logic [7:0] rx;
        bit         ea, el;
        spi_begin();
        spi_bits(8'h0A, 8, 1'b0, rx, ea, el);
        wr_exp_q.push_back({4'd10, 8'h6B}); model[10] = 8'h6B;
        spi_bits(8'h6B, 8, 1'b1, rx, ea, el);
        wait_clks(8);
        n_checks++;
        if (bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL csb_last_idle: busy=%0b, expected 0", bus.busy_o);
        end
        check_bank("csb_last");
    endtask

    task automatic test_random();
        bit         rw;
        int         len;
        logic [6:0] a;
        for (int it = 0; it < 16; it++) begin
            // sck activity with csb high must be ignored
            for (int t = 0; t < 3; t++) begin
                bus.spi_sck_i = 1'b1; wait_clks(H);
                bus.spi_sck_i = 1'b0; wait_clks(H);
            end
            n_checks++;
            if (bus.busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_idle_sck: busy=%0b, expected 0", bus.busy_o);
            end
            rw  = 1'($urandom_range(0, 1));
            a   = 7'($urandom_range(0, 127));
            len = $urandom_range(1, 4);
            if (rw) begin
                do_read({1'b1, a}, len);
            end else begin
                for (int k = 0; k < len; k++) burst_buf[k] = 8'($urandom_range(0, 255));
                do_write({1'b0, a}, len);
            end
        end
        check_bank("random");
    endtask

    initial begin
        bus.spi_sck_i = 1'b0;
        bus.spi_csb_i = 1'b1;
        bus.spi_sd_i  = 1'b0;
        model_reset();
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_csb_with_last_rise();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
